// File: rtl/mic_array_arbiter.sv
// -----------------------------------------------------------------------------
// mic_array_arbiter
//   Collects left/right samples from NUM_CH I2S receivers into 2*NUM_CH one-deep
//   slot registers. A round-robin arbiter moves them into a single valid/ready
//   output register. Slot s = 2*ch + side, where side 0 is left.
//
// Ports
//   i_sys_clk        clock, rising edge
//   rst              synchronous reset, active low
//   i_enable         capture enable; also drives the IDLE/RUN/DRAIN FSM
//   i_left_data/_vld, i_right_data/_vld
//                    per-channel samples and one-cycle valid pulses
//   o_data/o_slot/o_vld, i_rdy
//                    granted sample, its slot index, and the valid/ready pair
//   o_frame_done     one-cycle pulse after every slot has been handed off once
//   o_overrun        sticky flag, set when a full slot is overwritten;
//                    i_clr_overrun clears it
//   o_busy           high while in RUN or DRAIN
// -----------------------------------------------------------------------------

// Per-slot holding register. It holds one sample and a full bit.
//   load   sample strobe (valid pulse qualified by the enable)
//   drain  the arbiter takes this slot at this edge
//   ovr    an overwrite of undelivered data happens at this edge
module mic_array_arbiter_slot #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  drain,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  full,
   output logic                  ovr
);
   // A drain at the same edge makes room for the new sample, so it is not an overrun.
   assign ovr = load & full & ~drain;

   always_ff @(posedge clk) begin
      if (!rst) begin
         data <= '0;
         full <= 1'b0;
      end else if (load) begin
         data <= din;
         full <= 1'b1;
      end else if (drain) begin
         full <= 1'b0;
      end
   end
endmodule

module mic_array_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   localparam int NSLOT     = 2 * NUM_CH,
   localparam int SW        = $clog2(NSLOT)
) (
   input  logic                         i_sys_clk,
   input  logic                         rst,
   input  logic                         i_enable,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_left_data,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_right_data,
   input  logic [NUM_CH-1:0]            i_left_vld,
   input  logic [NUM_CH-1:0]            i_right_vld,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic [SW-1:0]                o_slot,
   output logic                         o_vld,
   input  logic                         i_rdy,
   output logic                         o_frame_done,
   output logic                         o_overrun,
   input  logic                         i_clr_overrun,
   output logic                         o_busy
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                             state;
   logic [NSLOT-1:0]                   load, drain, full, ovr;
   logic [NSLOT-1:0][DATA_WIDTH-1:0]   din, sdata;
   logic [NSLOT-1:0]                   mask, mask_nxt;
   logic [SW-1:0]                      rr_ptr, gnt, gnt_inc;
   logic                               gnt_vld, out_load, take, hs, pending, to_idle;
   int                                 idx;

   // Slot array. Even slots take the left sample and odd slots take the right sample.
   for (genvar g = 0; g < NSLOT; g++) begin : g_slot
      localparam int CH = g / 2;
      if ((g % 2) == 0) begin : g_left
         assign load[g] = i_enable & i_left_vld[CH];
         assign din[g]  = i_left_data[CH*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_right
         assign load[g] = i_enable & i_right_vld[CH];
         assign din[g]  = i_right_data[CH*DATA_WIDTH +: DATA_WIDTH];
      end
      mic_array_arbiter_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .clk   (i_sys_clk),
         .rst   (rst),
         .load  (load[g]),
         .drain (drain[g]),
         .din   (din[g]),
         .data  (sdata[g]),
         .full  (full[g]),
         .ovr   (ovr[g])
      );
   end

   // Round-robin search starts at rr_ptr. The loop runs from far to near, so the
   // nearest full slot is the last one written and wins.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % NSLOT;
         if (full[idx]) begin
            gnt_vld = 1'b1;
            gnt     = SW'(idx);
         end
      end
   end

   assign gnt_inc  = (gnt == SW'(NSLOT - 1)) ? '0 : gnt + 1'b1;
   assign out_load = ~o_vld | i_rdy;
   assign take     = out_load & gnt_vld;
   assign drain    = take ? (NSLOT'(1) << gnt) : '0;
   assign hs       = o_vld & i_rdy;
   assign mask_nxt = mask | (hs ? (NSLOT'(1) << o_slot) : '0);
   assign pending  = (|full) | o_vld;
   // The FSM falls back to IDLE from RUN or DRAIN under the same condition.
   assign to_idle  = (state != IDLE) & ~i_enable & ~pending;

   // Output register and round-robin pointer
   always_ff @(posedge i_sys_clk) begin
      if (!rst) begin
         o_vld  <= 1'b0;
         o_data <= '0;
         o_slot <= '0;
         rr_ptr <= '0;
      end else if (out_load) begin
         o_vld <= gnt_vld;
         if (gnt_vld) begin
            o_data <= sdata[gnt];
            o_slot <= gnt;
            rr_ptr <= gnt_inc;
         end
      end
   end

   // Frame tracking. The mask never holds all ones in a register. A completing
   // handshake pulses o_frame_done and clears the mask at the same edge.
   always_ff @(posedge i_sys_clk) begin
      if (!rst) begin
         mask         <= '0;
         o_frame_done <= 1'b0;
      end else if (to_idle) begin
         mask         <= '0;
         o_frame_done <= 1'b0;
      end else if (&mask_nxt) begin
         mask         <= '0;
         o_frame_done <= 1'b1;
      end else begin
         mask         <= mask_nxt;
         o_frame_done <= 1'b0;
      end
   end

   // A new overrun takes priority over a clear in the same cycle.
   always_ff @(posedge i_sys_clk) begin
      if (!rst) o_overrun <= 1'b0;
      else      o_overrun <= (|ovr) | (o_overrun & ~i_clr_overrun);
   end

   // Control FSM. o_busy is registered together with the state.
   always_ff @(posedge i_sys_clk) begin
      if (!rst) begin
         state  <= IDLE;
         o_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_enable) begin
               state  <= RUN;
               o_busy <= 1'b1;
            end
            RUN: if (!i_enable) begin
               if (pending) begin
                  state <= DRAIN;
               end else begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            end
            DRAIN: if (i_enable) begin
               state <= RUN;
            end else if (!pending) begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mic_array_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mic_array_arbiter
//   Directed vectors with hand-computed expectations for mic_array_arbiter
//   (NUM_CH=4, DATA_WIDTH=16). Inputs change 1 ns after each rising edge.
//   Outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mic_array_arbiter;
   localparam int DW  = 16;
   localparam int NCH = 4;

   logic              clk = 1'b0;
   logic              sys_rst_tb;
   logic              enable, rdy, clr_ovr;
   logic [NCH*DW-1:0] left_data, right_data;
   logic [NCH-1:0]    left_vld, right_vld;
   logic [DW-1:0]     data;
   logic [2:0]        slot;
   logic              vld, frame_done, overrun, busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mic_array_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
      .i_sys_clk     (clk),
      .rst           (sys_rst_tb),
      .i_enable      (enable),
      .i_left_data   (left_data),
      .i_right_data  (right_data),
      .i_left_vld    (left_vld),
      .i_right_vld   (right_vld),
      .o_data        (data),
      .o_slot        (slot),
      .o_vld         (vld),
      .i_rdy         (rdy),
      .o_frame_done  (frame_done),
      .o_overrun     (overrun),
      .i_clr_overrun (clr_ovr),
      .o_busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst_tb = 1'b0;
      enable     = 1'b0;
      rdy        = 1'b1;
      clr_ovr    = 1'b0;
      left_vld   = '0;
      right_vld  = '0;
      left_data  = '0;
      right_data = '0;
      tick();
      tick();
      sys_rst_tb = 1'b1;
      enable     = 1'b1;
      tick();           // IDLE -> RUN
   endtask

   logic seen_fd;

   initial begin
      // ---------------- reset values ----------------
      sys_rst_tb = 1'b0;
      enable = 1'b0; rdy = 1'b1; clr_ovr = 1'b0;
      left_vld = '0; right_vld = '0; left_data = '0; right_data = '0;
      tick();
      tick();
      chk("rst_vld",  vld, 0);
      chk("rst_data", data, 0);
      chk("rst_slot", slot, 0);
      chk("rst_fd",   frame_done, 0);
      chk("rst_ovr",  overrun, 0);
      chk("rst_busy", busy, 0);

      // ---------------- single sample latency: left ch2 -> slot 4 ----------------
      do_reset();
      chk("run_busy", busy, 1);
      left_data[2*DW +: DW] = 16'h1234;
      left_vld[2] = 1'b1;
      tick();                       // edge k: the slot fills
      left_vld = '0;
      chk("lat_k_vld", vld, 0);
      tick();                       // edge k+1: the output register loads
      chk("lat_vld",  vld, 1);
      chk("lat_slot", slot, 4);
      chk("lat_data", data, 16'h1234);
      tick();
      chk("lat_once", vld, 0);

      // ---------------- full frame: all 8 slots in the same cycle ----------------
      do_reset();
      for (int c = 0; c < NCH; c++) begin
         left_data[c*DW +: DW]  = 16'h00A0 + 16'(2*c);
         right_data[c*DW +: DW] = 16'h00A0 + 16'(2*c + 1);
      end
      left_vld = '1; right_vld = '1;
      tick();
      left_vld = '0; right_vld = '0;
      for (int s = 0; s < 2*NCH; s++) begin
         tick();
         chk($sformatf("frm_vld%0d", s),  vld, 1);
         chk($sformatf("frm_slot%0d", s), slot, s);
         chk($sformatf("frm_data%0d", s), data, 16'h00A0 + s);
         chk($sformatf("frm_fd%0d", s),   frame_done, 0);
      end
      tick();
      chk("frm_done",      frame_done, 1);
      chk("frm_vld_after", vld, 0);
      tick();
      chk("frm_done_once", frame_done, 0);

      // ---------------- overrun ----------------
      do_reset();
      rdy = 1'b0;
      right_data[0 +: DW] = 16'h5555;
      right_vld[0] = 1'b1;          // slot 1 goes to the output register and stalls
      tick();
      right_vld = '0;
      tick();
      chk("ovr_hold_slot", slot, 1);
      left_data[0 +: DW] = 16'hAAAA;
      left_vld[0] = 1'b1;
      tick();
      left_data[0 +: DW] = 16'hBBBB;
      tick();
      left_vld = '0;
      chk("ovr_set",      overrun, 1);
      chk("ovr_out_slot", slot, 1);
      rdy = 1'b1;
      tick();                       // handshake slot 1, then grant slot 0
      chk("ovr_s0_vld",  vld, 1);
      chk("ovr_s0_slot", slot, 0);
      chk("ovr_s0_data", data, 16'hBBBB);
      tick();
      chk("ovr_s0_once", vld, 0);
      chk("ovr_sticky",  overrun, 1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("ovr_clr", overrun, 0);
      // A clear in the same cycle as a new overrun leaves the flag set.
      rdy = 1'b0;
      left_vld[1] = 1'b1;
      tick();
      left_vld = '0;
      tick();                       // slot 2 is now stalled in the output register
      left_vld[1] = 1'b1;
      tick();                       // slot 2 fills again
      clr_ovr = 1'b1;
      tick();                       // overwrite and clear in the same cycle
      left_vld = '0;
      clr_ovr = 1'b0;
      chk("ovr_wins", overrun, 1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("ovr_clr2", overrun, 0);

      // ---------------- backpressure hold + drain ----------------
      do_reset();
      rdy = 1'b0;
      left_data[1*DW +: DW]  = 16'h2222;
      right_data[1*DW +: DW] = 16'h3333;
      left_data[3*DW +: DW]  = 16'h6666;
      left_vld[1] = 1'b1; right_vld[1] = 1'b1; left_vld[3] = 1'b1;
      tick();
      left_vld = '0; right_vld = '0;
      tick();                       // slot 2 is in the output register
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("hold_vld%0d", i),  vld, 1);
         chk($sformatf("hold_slot%0d", i), slot, 2);
         chk($sformatf("hold_data%0d", i), data, 16'h2222);
      end
      enable = 1'b0;
      tick();                       // RUN -> DRAIN
      chk("drn_busy0", busy, 1);
      rdy = 1'b1;
      tick();
      chk("drn_slot3", slot, 3);
      chk("drn_data3", data, 16'h3333);
      chk("drn_busy1", busy, 1);
      tick();
      chk("drn_slot6", slot, 6);
      chk("drn_data6", data, 16'h6666);
      chk("drn_busy2", busy, 1);
      tick();                       // last handshake
      chk("drn_vld_off", vld, 0);
      chk("drn_busy3",   busy, 1);
      tick();                       // DRAIN -> IDLE
      chk("drn_idle", busy, 0);

      // ---------------- reset in the middle of a transfer ----------------
      do_reset();
      rdy = 1'b0;
      left_vld[0] = 1'b1; right_vld[0] = 1'b1; left_vld[1] = 1'b1; right_vld[1] = 1'b1;
      left_data[0 +: DW] = 16'h0F0F;
      tick();
      left_vld = '0; right_vld = '0;
      tick();
      chk("mid_vld", vld, 1);
      sys_rst_tb = 1'b0;
      tick();
      chk("mid_rst_vld",  vld, 0);
      chk("mid_rst_data", data, 0);
      chk("mid_rst_slot", slot, 0);
      chk("mid_rst_fd",   frame_done, 0);
      chk("mid_rst_ovr",  overrun, 0);
      chk("mid_rst_busy", busy, 0);
      sys_rst_tb = 1'b1;
      rdy = 1'b1;
      enable = 1'b1;
      seen_fd = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("mid_discard%0d", i), vld, 0);
         seen_fd |= frame_done;
      end
      // Deliver every slot except 7. The frame must not complete.
      left_vld = '1; right_vld = 4'b0111;
      tick();
      left_vld = '0; right_vld = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen_fd |= frame_done;
      end
      chk("mid_no_fd", seen_fd, 0);
      right_vld[3] = 1'b1;
      tick();
      right_vld = '0;
      tick();
      chk("mid_s7_slot", slot, 7);
      tick();
      chk("mid_fd", frame_done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mic_array_arbiter.md
MIC_ARRAY_ARBITER -- requirements
Module: mic_array_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, sample width in bits.
REQ-002 Parameter: NUM_CH, default 4, number of I2S receiver channels; slots = 2*NUM_CH (slot s = 2*ch + side, side 0 = left).
REQ-003 Port: i_sys_clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-low.
REQ-005 Port: i_enable  in  1  capture enable.
REQ-006 Port: i_left_data / i_right_data  in  NUM_CH*DATA_WIDTH each  per-channel samples; ch c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-007 Port: i_left_vld / i_right_vld  in  NUM_CH each  one-cycle sample-valid pulses per channel.
REQ-008 Port: o_data  out  DATA_WIDTH  granted sample.
REQ-009 Port: o_slot  out  clog2(2*NUM_CH)  slot index of o_data.
REQ-010 Port: o_vld  out  1  output valid; i_rdy  in  1  downstream ready.
REQ-011 Port: o_frame_done  out  1  one-cycle pulse, full frame delivered.
REQ-012 Port: o_overrun  out  1  sticky overrun flag; i_clr_overrun  in  1  clears it.
REQ-013 Port: o_busy  out  1  high in RUN or DRAIN.

Function
REQ-014 Each slot SHALL have a one-deep holding register plus full bit; a vld pulse with i_enable high SHALL load the sample and set full at that edge.
REQ-015 With i_enable low, vld pulses SHALL be ignored.
REQ-016 A vld pulse into a full slot not drained that cycle SHALL overwrite the data, keep full set, and set o_overrun.
REQ-017 A vld pulse into a slot drained the same cycle SHALL store the new sample, keep full set, and SHALL NOT set o_overrun.
REQ-018 Output register: load when o_vld low or (o_vld and i_rdy); otherwise o_data/o_slot/o_vld SHALL hold stable.
REQ-019 Grant: round-robin over full slots, search starting at (last granted slot + 1) mod 2*NUM_CH; after reset, search starts at slot 0.
REQ-020 Loading the output register SHALL clear the granted slot's full bit at the same edge.
REQ-021 Latency: vld sampled at edge k, output register empty, no competing slots -> o_vld high after edge k+1.
REQ-022 Frame mask (2*NUM_CH bits) SHALL set bit o_slot on each o_vld&&i_rdy handshake; repeat slots leave mask unchanged.
REQ-023 When the mask becomes all ones, o_frame_done SHALL pulse in the following cycle and the mask SHALL clear at that same edge.
REQ-024 FSM states: IDLE, RUN, DRAIN.
REQ-025 IDLE -> RUN when i_enable high; RUN -> DRAIN when i_enable low and any slot full or o_vld high; RUN -> IDLE when i_enable low and nothing pending.
REQ-026 DRAIN -> IDLE when no slot full and o_vld low; DRAIN -> RUN when i_enable high again.
REQ-027 Entering IDLE SHALL clear the frame mask; o_frame_done SHALL NOT pulse on that transition.
REQ-028 i_clr_overrun SHALL clear o_overrun; a simultaneous new overrun SHALL win (flag stays set).

Reset
REQ-029 While rst is low at a clock edge: state IDLE, all full bits 0, frame mask 0, round-robin pointer to slot 0, o_vld 0, o_data 0, o_slot 0, o_frame_done 0, o_overrun 0, o_busy 0.
REQ-030 Reset mid-transfer SHALL discard pending samples without producing a handshake or frame_done.

Verification
REQ-031 NUM_CH=4, i_rdy=1, i_left_vld[2] pulse with data 16'h1234 at edge k -> o_vld=1, o_slot=4, o_data=16'h1234 after edge k+1, one cycle only.
REQ-032 All 8 vld bits pulsed same cycle, i_rdy=1 -> slots delivered in order 0..7 on consecutive cycles, o_frame_done pulses once the cycle after slot 7.
REQ-033 i_rdy=0, i_left_vld[0] pulsed twice (16'hAAAA then 16'hBBBB) -> o_overrun=1; after i_rdy=1, slot 0 output once with 16'hBBBB.
REQ-034 i_rdy held low 5 cycles while o_vld=1 -> o_data/o_slot unchanged throughout; drop i_enable with pending slots -> o_busy stays 1 until last handshake, then IDLE.
REQ-035 Assert rst low with 3 slots pending and o_vld=1 -> next cycle all outputs at reset values; no o_frame_done afterwards until a full new frame is delivered.
